// File: rtl/fc_pkg.sv
// fc_pkg: shared definitions for the fully-connected stream engine.
//   state_t      - frame-walking FSM states (LOAD_BIAS, LOAD_FEAT, MAC, SEND)
//   DEF_*        - default widths and sizes used as parameter defaults
//   SAT_W        - working width of the generic saturation helper
//   sat_to_data  - clamps a wide signed value to the signed range of a
//                  dw-bit word; callers keep the low dw bits of the result
package fc_pkg;

  typedef enum logic [1:0] {
    LOAD_BIAS = 2'd0,
    LOAD_FEAT = 2'd1,
    MAC       = 2'd2,
    SEND      = 2'd3
  } state_t;

  localparam int DEF_DATA_WIDTH  = 32;
  localparam int DEF_INPUT_SIZE  = 64;
  localparam int DEF_OUTPUT_SIZE = 10;
  localparam int DEF_ACC_WIDTH   = 2 * DEF_DATA_WIDTH + 8;

  // Wide enough for any accumulator this engine is expected to carry.
  localparam int SAT_W = 256;

  function automatic logic signed [SAT_W-1:0] sat_to_data(
    input logic signed [SAT_W-1:0] val,
    input int unsigned             dw
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) << (dw - 1)) - SAT_W'(1);
    // Two's complement: -(2^(dw-1)) is the bitwise inverse of 2^(dw-1)-1.
    min_v = ~max_v;
    if (val > max_v) begin
      sat_to_data = max_v;
    end else if (val < min_v) begin
      sat_to_data = min_v;
    end else begin
      sat_to_data = val;
    end
  endfunction

endpackage

// File: rtl/fc_mac_sat.sv
// fc_mac_sat: combinational multiply-accumulate step with output clamp.
//   base      in  ACC_WIDTH   running sum (or the sign-extended bias at i==0)
//   feature   in  DATA_WIDTH  stored feature
//   weight    in  DATA_WIDTH  weight word from the input stream
//   acc_next  out ACC_WIDTH   base + full-precision feature*weight
//   result    out DATA_WIDTH  acc_next saturated to the signed word range
// Optional build macro FC_RELU_EN: when defined, negative saturated
// results are replaced by zero.
module fc_mac_sat
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  = DEF_ACC_WIDTH
)
(
  input  logic signed [ACC_WIDTH-1:0]  base,
  input  logic signed [DATA_WIDTH-1:0] feature,
  input  logic signed [DATA_WIDTH-1:0] weight,
  output logic signed [ACC_WIDTH-1:0]  acc_next,
  output logic signed [DATA_WIDTH-1:0] result
);

  logic signed [2*DATA_WIDTH-1:0] prod;
  logic signed [DATA_WIDTH-1:0]   sat_val;

  // Both operands are signed, so they are sign-extended to the full
  // 2*DATA_WIDTH product width before multiplying.
  assign prod     = feature * weight;
  assign acc_next = base + ACC_WIDTH'(prod);
  assign sat_val  = DATA_WIDTH'(sat_to_data(SAT_W'(acc_next), DATA_WIDTH));

`ifdef FC_RELU_EN
  assign result = sat_val[DATA_WIDTH-1] ? '0 : sat_val;
`else
  assign result = sat_val;
`endif

endmodule

// File: rtl/fc_stream.sv
// fc_stream: fully-connected layer engine over AXI-Stream.
// One input frame carries OUTPUT_SIZE biases, INPUT_SIZE features and then
// INPUT_SIZE*OUTPUT_SIZE weights (row-major per output neuron). Weights are
// consumed as they arrive; each finished row is saturated into out_buf and
// the OUTPUT_SIZE results are streamed out once the frame is complete.
// Ports:
//   clk, rstn        clock (rising edge), asynchronous active-low reset
//   S_AXIS_*         input stream (TDATA/TVALID/TREADY/TLAST)
//   M_AXIS_*         result stream (TDATA/TVALID/TREADY/TLAST)
//   busy             state != LOAD_BIAS or a word counter non-zero
//   err              sticky framing error, cleared only by reset
// Optional build macro FC_RELU_EN (applied inside fc_mac_sat).
module fc_stream
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
  parameter int INPUT_SIZE  = DEF_INPUT_SIZE,
  parameter int OUTPUT_SIZE = DEF_OUTPUT_SIZE,
  parameter int ACC_WIDTH   = 2 * DATA_WIDTH + 8
)
(
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic                  S_AXIS_TLAST,
  output logic [DATA_WIDTH-1:0] M_AXIS_TDATA,
  output logic                  M_AXIS_TVALID,
  input  logic                  M_AXIS_TREADY,
  output logic                  M_AXIS_TLAST,
  output logic                  busy,
  output logic                  err
);

  localparam int IW = (INPUT_SIZE  > 1) ? $clog2(INPUT_SIZE)  : 1;
  localparam int OW = (OUTPUT_SIZE > 1) ? $clog2(OUTPUT_SIZE) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(INPUT_SIZE - 1);
  localparam logic [OW-1:0] O_LAST = OW'(OUTPUT_SIZE - 1);

  state_t                      state;
  // i_cnt indexes features, o_cnt indexes biases / output rows / results.
  logic [IW-1:0]               i_cnt;
  logic [OW-1:0]               o_cnt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic                        s_ready;
  logic                        m_valid;
  logic                        m_last;
  logic                        err_q;

  logic signed [DATA_WIDTH-1:0] bias_buf [OUTPUT_SIZE];
  logic signed [DATA_WIDTH-1:0] feat_buf [INPUT_SIZE];
  logic signed [DATA_WIDTH-1:0] out_buf  [OUTPUT_SIZE];

  logic                         s_beat;
  logic                         m_beat;
  logic                         i_end;
  logic                         o_end;
  logic signed [ACC_WIDTH-1:0]  mac_base;
  logic signed [ACC_WIDTH-1:0]  acc_next;
  logic signed [DATA_WIDTH-1:0] mac_result;

  assign s_beat = S_AXIS_TVALID && s_ready;
  assign m_beat = m_valid && M_AXIS_TREADY;
  assign i_end  = (i_cnt == I_LAST);
  assign o_end  = (o_cnt == O_LAST);

  // The first weight of a row restarts the sum from that row's bias.
  assign mac_base = (i_cnt == '0) ? ACC_WIDTH'(bias_buf[o_cnt]) : acc;

  fc_mac_sat #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_mac (
    .base     (mac_base),
    .feature  (feat_buf[i_cnt]),
    .weight   (S_AXIS_TDATA),
    .acc_next (acc_next),
    .result   (mac_result)
  );

  // Control: FSM, counters, accumulator and registered handshake outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= LOAD_BIAS;
      i_cnt   <= '0;
      o_cnt   <= '0;
      acc     <= '0;
      s_ready <= 1'b0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        LOAD_BIAS: begin
          s_ready <= 1'b1;
          if (s_beat) begin
            if (S_AXIS_TLAST) begin
              err_q <= 1'b1;
              o_cnt <= '0;
            end else if (o_end) begin
              o_cnt <= '0;
              state <= LOAD_FEAT;
            end else begin
              o_cnt <= o_cnt + 1'b1;
            end
          end
        end

        LOAD_FEAT: begin
          if (s_beat) begin
            if (S_AXIS_TLAST) begin
              err_q <= 1'b1;
              i_cnt <= '0;
              o_cnt <= '0;
              state <= LOAD_BIAS;
            end else if (i_end) begin
              i_cnt <= '0;
              state <= MAC;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
        end

        MAC: begin
          if (s_beat) begin
            acc <= acc_next;
            if (S_AXIS_TLAST && !(i_end && o_end)) begin
              // Early TLAST: drop the frame and wait for a new one.
              err_q <= 1'b1;
              i_cnt <= '0;
              o_cnt <= '0;
              state <= LOAD_BIAS;
            end else if (i_end) begin
              i_cnt <= '0;
              if (o_end) begin
                // Final weight: results are complete, TLAST or not.
                o_cnt   <= '0;
                state   <= SEND;
                s_ready <= 1'b0;
                m_valid <= 1'b1;
                m_last  <= (OUTPUT_SIZE == 1);
                if (!S_AXIS_TLAST) begin
                  err_q <= 1'b1;
                end
              end else begin
                o_cnt <= o_cnt + 1'b1;
              end
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
        end

        SEND: begin
          if (m_beat) begin
            if (o_end) begin
              o_cnt   <= '0;
              state   <= LOAD_BIAS;
              m_valid <= 1'b0;
              m_last  <= 1'b0;
              s_ready <= 1'b1;
            end else begin
              o_cnt  <= o_cnt + 1'b1;
              m_last <= ((o_cnt + 1'b1) == O_LAST);
            end
          end
        end

        default: state <= LOAD_BIAS;
      endcase
    end
  end

  // Datapath storage: written only on accepted input beats, never reset.
  always_ff @(posedge clk) begin
    if (s_beat) begin
      case (state)
        LOAD_BIAS: bias_buf[o_cnt] <= S_AXIS_TDATA;
        LOAD_FEAT: feat_buf[i_cnt] <= S_AXIS_TDATA;
        MAC: begin
          if (i_end) begin
            out_buf[o_cnt] <= mac_result;
          end
        end
        default: ;
      endcase
    end
  end

  assign S_AXIS_TREADY = s_ready;
  assign M_AXIS_TVALID = m_valid;
  assign M_AXIS_TLAST  = m_last;
  // Gated by m_valid so the data bus reads zero outside SEND and in reset.
  assign M_AXIS_TDATA  = m_valid ? out_buf[o_cnt] : '0;
  assign busy          = (state != LOAD_BIAS) || (o_cnt != '0) || (i_cnt != '0);
  assign err           = err_q;

endmodule

// File: tb/tb_fc_stream.sv
// Scoreboard bench for fc_stream: a 4x2 instance for the directed frames and
// a default 64x10 instance checked against a reference model.
module tb_fc_stream;

`ifdef FC_RELU_EN
  localparam bit RELU = 1'b1;
`else
  localparam bit RELU = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rstn;

  logic [31:0] s_tdata_s, m_tdata_s;
  logic        s_tvalid_s, s_tready_s, s_tlast_s;
  logic        m_tvalid_s, m_tready_s, m_tlast_s, busy_s, err_s;
  logic [31:0] s_tdata_b, m_tdata_b;
  logic        s_tvalid_b, s_tready_b, s_tlast_b;
  logic        m_tvalid_b, m_tready_b, m_tlast_b, busy_b, err_b;

  fc_stream #(.DATA_WIDTH(32), .INPUT_SIZE(4), .OUTPUT_SIZE(2)) u_small (
    .clk(clk), .rstn(rstn),
    .S_AXIS_TDATA(s_tdata_s), .S_AXIS_TVALID(s_tvalid_s), .S_AXIS_TREADY(s_tready_s),
    .S_AXIS_TLAST(s_tlast_s),
    .M_AXIS_TDATA(m_tdata_s), .M_AXIS_TVALID(m_tvalid_s), .M_AXIS_TREADY(m_tready_s),
    .M_AXIS_TLAST(m_tlast_s), .busy(busy_s), .err(err_s)
  );

  fc_stream #(.DATA_WIDTH(32), .INPUT_SIZE(64), .OUTPUT_SIZE(10)) u_big (
    .clk(clk), .rstn(rstn),
    .S_AXIS_TDATA(s_tdata_b), .S_AXIS_TVALID(s_tvalid_b), .S_AXIS_TREADY(s_tready_b),
    .S_AXIS_TLAST(s_tlast_b),
    .M_AXIS_TDATA(m_tdata_b), .M_AXIS_TVALID(m_tvalid_b), .M_AXIS_TREADY(m_tready_b),
    .M_AXIS_TLAST(m_tlast_b), .busy(busy_b), .err(err_b)
  );

  int n_checks = 0;
  int n_pass   = 0;

  typedef struct packed { logic [31:0] d; logic l; } exp_t;
  exp_t        q_s[$];
  exp_t        q_b[$];
  logic [31:0] fr[$];
  bit          rnd_ready = 1'b0;
  int          outs_s = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic set_in(input bit big, input logic v, input logic [31:0] d, input logic l);
    if (big) begin
      s_tvalid_b = v; s_tdata_b = d; s_tlast_b = l;
    end else begin
      s_tvalid_s = v; s_tdata_s = d; s_tlast_s = l;
    end
  endtask

  // Sends fr[0..nbeats-1]; called and returns at posedge+1.
  task automatic drive(input bit big, input int nbeats, input int last_idx, input bit gaps);
    for (int n = 0; n < nbeats; n++) begin
      int t;
      bit hs;
      if (gaps) begin
        while ($urandom_range(0, 2) == 0) begin
          set_in(big, 1'b0, 32'd0, 1'b0);
          @(posedge clk); #1;
        end
      end
      set_in(big, 1'b1, fr[n], n == last_idx);
      t = 0;
      forever begin
        @(negedge clk);
        hs = big ? s_tready_b : s_tready_s;
        if (big && n == nbeats - 1) check("big_valid_before_final_weight", 64'(m_tvalid_b), 64'(0));
        @(posedge clk); #1;
        if (hs) break;
        t++;
        if (t > 1000) begin
          n_checks++;
          $display("FAIL input_handshake_timeout: got no TREADY at beat %0d, expected TREADY", n);
          set_in(big, 1'b0, 32'd0, 1'b0);
          return;
        end
      end
    end
    set_in(big, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic wait_drain(input bit big);
    int t = 0;
    while ((big ? q_b.size() : q_s.size()) != 0 && t < 5000) begin
      @(posedge clk);
      t++;
    end
    #1;
    if ((big ? q_b.size() : q_s.size()) != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d results pending, expected 0",
               big ? q_b.size() : q_s.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_reset_s(input string tag);
    check({tag, "_s_tready"}, 64'(s_tready_s), 64'(0));
    check({tag, "_m_tvalid"}, 64'(m_tvalid_s), 64'(0));
    check({tag, "_m_tlast"},  64'(m_tlast_s),  64'(0));
    check({tag, "_m_tdata"},  64'(m_tdata_s),  64'(0));
    check({tag, "_busy"},     64'(busy_s),     64'(0));
    check({tag, "_err"},      64'(err_s),      64'(0));
  endtask

  task automatic basic_frame();
    fr = {32'd1, 32'd2, 32'd1, 32'd2, 32'd3, 32'd4,
          32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7, 32'd8};
  endtask

  task automatic push_basic();
    q_s.push_back('{d: 32'd31, l: 1'b0});
    q_s.push_back('{d: 32'd72, l: 1'b1});
  endtask

  // Random downstream backpressure for the small instance.
  initial forever begin
    @(posedge clk); #1;
    if (rnd_ready) m_tready_s = ($urandom_range(0, 1) == 1);
  end

  // Small-instance monitor: pops the scoreboard on every output handshake.
  initial begin
    bit          hold;
    logic [31:0] hold_d;
    exp_t        e;
    hold = 1'b0;
    hold_d = '0;
    forever begin
      @(negedge clk);
      if (rstn && m_tvalid_s) begin
        check("small_s_tready_low_in_send", 64'(s_tready_s), 64'(0));
        if (hold) check("small_tdata_stable", 64'(m_tdata_s), 64'(hold_d));
        if (m_tready_s) begin
          outs_s++;
          if (q_s.size() == 0) begin
            n_checks++;
            $display("FAIL small_unexpected_output: got 0x%0h, expected no output", m_tdata_s);
          end else begin
            e = q_s.pop_front();
            check("small_tdata", 64'(m_tdata_s), 64'(e.d));
            check("small_tlast", 64'(m_tlast_s), 64'(e.l));
          end
          hold = 1'b0;
        end else begin
          hold = 1'b1;
          hold_d = m_tdata_s;
        end
      end else begin
        hold = 1'b0;
      end
    end
  end

  // Big-instance monitor (downstream always ready).
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rstn && m_tvalid_b && m_tready_b) begin
        check("big_s_tready_low_in_send", 64'(s_tready_b), 64'(0));
        if (q_b.size() == 0) begin
          n_checks++;
          $display("FAIL big_unexpected_output: got 0x%0h, expected no output", m_tdata_b);
        end else begin
          e = q_b.pop_front();
          check("big_tdata", 64'(m_tdata_b), 64'(e.d));
          check("big_tlast", 64'(m_tlast_b), 64'(e.l));
        end
      end
    end
  end

  initial begin
    int   outs_before;
    longint acc;
    rstn = 1'b0;
    set_in(1'b0, 1'b0, 32'd0, 1'b0);
    set_in(1'b1, 1'b0, 32'd0, 1'b0);
    m_tready_s = 1'b1;
    m_tready_b = 1'b1;
    repeat (3) @(posedge clk); #1;
    check_reset_s("reset");
    check("reset_big_m_tvalid", 64'(m_tvalid_b), 64'(0));
    check("reset_big_s_tready", 64'(s_tready_b), 64'(0));
    rstn = 1'b1;
    @(posedge clk); #1;
    check("s_tready_after_reset", 64'(s_tready_s), 64'(1));

    // Clean frame, downstream always ready.
    basic_frame(); push_basic();
    drive(1'b0, 14, 13, 1'b0);
    wait_drain(1'b0);
    check("clean_err", 64'(err_s), 64'(0));
    check("clean_busy_idle", 64'(busy_s), 64'(0));

    // Same frame with input gaps and random backpressure.
    basic_frame(); push_basic();
    rnd_ready = 1'b1;
    drive(1'b0, 14, 13, 1'b1);
    wait_drain(1'b0);
    rnd_ready = 1'b0;
    #2 m_tready_s = 1'b1;
    @(posedge clk); #1;
    check("gaps_err", 64'(err_s), 64'(0));

    // Saturation: row 0 overflows positive, row 1 negative.
    fr = {32'h7FFF_FFF0, 32'h8000_0000,
          32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
          32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000,
          32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000, 32'hFFFF_0000};
    q_s.push_back('{d: 32'h7FFF_FFFF, l: 1'b0});
    q_s.push_back('{d: RELU ? 32'h0 : 32'h8000_0000, l: 1'b1});
    drive(1'b0, 14, 13, 1'b0);
    wait_drain(1'b0);
    check("sat_err", 64'(err_s), 64'(0));

    // TLAST on feature 2: frame dropped, sticky error.
    outs_before = outs_s;
    basic_frame();
    drive(1'b0, 4, 3, 1'b0);
    repeat (20) @(posedge clk); #1;
    check("early_tlast_no_output", 64'(outs_s), 64'(outs_before));
    check("early_tlast_err", 64'(err_s), 64'(1));
    check("early_tlast_busy", 64'(busy_s), 64'(0));
    basic_frame(); push_basic();
    drive(1'b0, 14, 13, 1'b0);
    wait_drain(1'b0);
    check("after_error_err_sticky", 64'(err_s), 64'(1));

    // Reset during MAC.
    basic_frame();
    drive(1'b0, 8, -1, 1'b0);
    #2 rstn = 1'b0;
    #1 check_reset_s("rst_mac");
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    // Reset during a stalled SEND.
    m_tready_s = 1'b0;
    basic_frame();
    drive(1'b0, 14, 13, 1'b0);
    @(negedge clk);
    check("stall_first_valid", 64'(m_tvalid_s), 64'(1));
    repeat (5) @(negedge clk);
    check("stall_valid_held", 64'(m_tvalid_s), 64'(1));
    check("stall_tdata_row0", 64'(m_tdata_s), 64'(31));
    #1 rstn = 1'b0;
    #1 check_reset_s("rst_send");
    m_tready_s = 1'b1;
    @(posedge clk); #1 rstn = 1'b1;
    @(posedge clk); #1;

    basic_frame(); push_basic();
    drive(1'b0, 14, 13, 1'b0);
    wait_drain(1'b0);
    check("post_reset_err", 64'(err_s), 64'(0));

    // Missing TLAST on the final weight: results still come out, err set.
    basic_frame(); push_basic();
    drive(1'b0, 14, -1, 1'b0);
    wait_drain(1'b0);
    check("missing_tlast_err", 64'(err_s), 64'(1));

    // Default-size instance against the reference model.
    fr.delete();
    for (int k = 0; k < 10; k++) fr.push_back(32'(k + 1));
    for (int i = 0; i < 64; i++) fr.push_back(32'(i + 1));
    for (int n = 0; n < 640; n++) fr.push_back(32'(n + 1));
    for (int o = 0; o < 10; o++) begin
      acc = longint'(o + 1);
      for (int i = 0; i < 64; i++) acc += longint'(i + 1) * longint'(o * 64 + i + 1);
      if (acc > 64'sd2147483647) acc = 64'sd2147483647;
      if (acc < -64'sd2147483648) acc = -64'sd2147483648;
      if (RELU && acc < 0) acc = 0;
      q_b.push_back('{d: 32'(acc), l: (o == 9)});
    end
    drive(1'b1, 714, 713, 1'b0);
    @(negedge clk);
    check("big_first_valid_latency", 64'(m_tvalid_b), 64'(1));
    wait_drain(1'b1);
    check("big_err", 64'(err_b), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
